rx_peak_scheduler: RTL

Sequences one receive-detection cycle around the peak-identification datapath in the RX chain. The block arms that datapath, timestamps the first filtered-signal threshold crossing, and bounds the correlation window. It then collects the winning sequence/peak and presents it to the ARM side through a valid/ack handshake, followed by a blanking hold-off. It sits between the band-pass/correlator/peak datapath and the ARM register interface.

---
 rtl/rx_peak_scheduler_if.sv | 32 +++
 rtl/rx_peak_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rx_peak_scheduler_if.sv
// Signal bundle between rx_peak_scheduler, the peak datapath and the ARM register side.
// The scheduler uses the slave modport; whoever drives commands and datapath results uses master.
interface rx_peak_scheduler_if;
    logic                istart;
    logic                istop;
    logic                idetect;
    logic        [32:0]  icurrent_time;
    logic                ipeak_done;
    logic signed [15:0]  ipeak_sample;
    logic        [3:0]   ipeak_seq;
    logic                iack;

    logic                oerx_en_peak;
    logic                o_valid;
    logic signed [15:0]  o_sample;
    logic        [3:0]   o_seq;
    logic        [32:0]  o_time;
    logic                o_err;
    logic                o_timeout;
    logic        [7:0]   o_reject_cnt;
    logic        [2:0]   o_state;

    modport slave (
        input  istart, istop, idetect, icurrent_time, ipeak_done, ipeak_sample, ipeak_seq, iack,
        output oerx_en_peak, o_valid, o_sample, o_seq, o_time, o_err, o_timeout, o_reject_cnt, o_state
    );

    modport master (
        output istart, istop, idetect, icurrent_time, ipeak_done, ipeak_sample, ipeak_seq, iack,
        input  oerx_en_peak, o_valid, o_sample, o_seq, o_time, o_err, o_timeout, o_reject_cnt, o_state
    );
endinterface

// File: rtl/rx_peak_scheduler.sv
// Receive-detection sequencer: arm peak datapath, timestamp detection, bound the window, report, hold off.
// Optional listen timeout is enabled by defining RX_SCHED_TIMEOUT_EN.
module rx_peak_scheduler #(
    parameter int unsigned        WINDOW_CYCLES  = 16400,
    parameter int unsigned        HOLDOFF_CYCLES = 1024,
    parameter int unsigned        TIMEOUT_CYCLES = 1000000,
    parameter logic signed [15:0] MIN_PEAK       = 16'sd200
) (
    input  logic               crx_clk,
    input  logic               rrx_rst_n,
    rx_peak_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LISTEN  = 3'd1,
        S_CAPTURE = 3'd2,
        S_REPORT  = 3'd3,
        S_HOLDOFF = 3'd4
    } state_e;

    localparam logic [16:0] WIN_LAST  = 17'(WINDOW_CYCLES - 32'd1);
    // A zero hold-off still spends one cycle blanked.
    localparam logic [16:0] HOLD_LAST = (HOLDOFF_CYCLES == 32'd0) ? 17'd0 : 17'(HOLDOFF_CYCLES - 32'd1);

    state_e             state_q, state_d;
    logic        [16:0] cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               valid_q, valid_d;
    logic signed [15:0] sample_q, sample_d;
    logic        [3:0]  seq_q, seq_d;
    logic        [32:0] time_q, time_d;
    logic               err_q, err_d;
    logic        [7:0]  rej_q, rej_d;

`ifdef RX_SCHED_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d;
`else
    logic tmo_unused_s;
    assign tmo_unused_s = |32'(TIMEOUT_CYCLES);
`endif

    // Next-state, counter and output-register logic; istop overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        seq_d    = seq_q;
        time_d   = time_q;
        err_d    = 1'b0;
        rej_d    = rej_q;
`ifdef RX_SCHED_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = 1'b0;
`endif
        if (bus.istop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.istart) state_d = S_LISTEN;
                    else            state_d = S_IDLE;
                end
                S_LISTEN: begin
                    if (bus.idetect) begin
                        state_d = S_CAPTURE;
                        time_d  = bus.icurrent_time;
                    end
`ifdef RX_SCHED_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = S_IDLE;
                        tmo_d   = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
`else
                    else begin
                        state_d = S_LISTEN;
                    end
`endif
                end
                S_CAPTURE: begin
                    // A result on the final window cycle takes priority over the abort.
                    if (bus.ipeak_done) begin
                        if (bus.ipeak_sample >= MIN_PEAK) begin
                            state_d  = S_REPORT;
                            sample_d = bus.ipeak_sample;
                            seq_d    = bus.ipeak_seq;
                        end else begin
                            state_d = S_HOLDOFF;
                            rej_d   = (rej_q == 8'hFF) ? rej_q : rej_q + 8'd1;
                        end
                    end else if (cnt_q == WIN_LAST) begin
                        state_d = S_HOLDOFF;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 17'd1;
                    end
                end
                S_REPORT: begin
                    if (bus.iack) state_d = S_HOLDOFF;
                    else          state_d = S_REPORT;
                end
                S_HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) state_d = S_LISTEN;
                    else                    cnt_d   = cnt_q + 17'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        cnt_d   = (state_d != state_q) ? 17'd0 : cnt_d;
        rej_d   = (state_d == S_IDLE) ? 8'd0 : rej_d;
`ifdef RX_SCHED_TIMEOUT_EN
        tmo_cnt_d = (state_d != state_q) ? 32'd0 : tmo_cnt_d;
`endif
        en_d    = (state_d == S_LISTEN) || (state_d == S_CAPTURE);
        valid_d = (state_d == S_REPORT);
    end

    // State and output registers.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 17'd0;
            en_q     <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= 16'sd0;
            seq_q    <= 4'd0;
            time_q   <= 33'd0;
            err_q    <= 1'b0;
            rej_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            seq_q    <= seq_d;
            time_q   <= time_d;
            err_q    <= err_d;
            rej_q    <= rej_d;
        end
    end

`ifdef RX_SCHED_TIMEOUT_EN
    // Listen timeout counter and pulse.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            tmo_cnt_q <= 32'd0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
    assign bus.o_timeout = tmo_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.oerx_en_peak = en_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_sample     = sample_q;
    assign bus.o_seq        = seq_q;
    assign bus.o_time       = time_q;
    assign bus.o_err        = err_q;
    assign bus.o_reject_cnt = rej_q;
    assign bus.o_state      = state_q;

endmodule
